// File: rtl/sa_pg_seq_pkg.sv
// Shared types, default parameters and counter sizing for the power-gating sequencer.
package sa_pg_pkg;

  typedef enum logic [2:0] {
    ST_ON,
    ST_ISO_ON,
    ST_PD_STEP,
    ST_PD_SETTLE,
    ST_OFF,
    ST_PU_STEP,
    ST_PU_SETTLE,
    ST_ISO_OFF
  } sa_pg_state_e;

  localparam int SA_PG_NUM_BANKS_DFLT = 4;
  localparam int SA_PG_STEP_CYC_DFLT  = 8;
  localparam int SA_PG_ISO_CYC_DFLT   = 2;

  // Wide enough to hold the longest phase length without wrapping.
  function automatic int sa_pg_cnt_w(input int step_cyc, input int iso_cyc);
    int m;
    m = (step_cyc > iso_cyc) ? step_cyc : iso_cyc;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/sa_pg_seq_if.sv
// Request/ack handshake and power-control outputs of sa_pg_seq.
// Optional pg_force_on appears when SA_PG_SEQ_FORCE_ON_EN is defined.
interface sa_pg_seq_if #(
  parameter int NUM_BANKS = 4
);
  logic                 pg_req;
  logic                 pg_ack;
  logic                 pg_busy;
  logic                 iso_en;
  logic [NUM_BANKS-1:0] bank_pd_en;
`ifdef SA_PG_SEQ_FORCE_ON_EN
  logic                 pg_force_on;

  modport master (output pg_req, output pg_force_on,
                  input pg_ack, input pg_busy, input iso_en, input bank_pd_en);
  modport slave  (input pg_req, input pg_force_on,
                  output pg_ack, output pg_busy, output iso_en, output bank_pd_en);
`else
  modport master (output pg_req,
                  input pg_ack, input pg_busy, input iso_en, input bank_pd_en);
  modport slave  (input pg_req,
                  output pg_ack, output pg_busy, output iso_en, output bank_pd_en);
`endif
endinterface

// File: rtl/sa_pg_seq_step_cnt.sv
// Loadable down-counter with zero flag; times every wait phase of the sequencer.
module sa_pg_step_cnt #(
  parameter int CNT_W = 4
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  output logic             o_zero
);
  logic [CNT_W-1:0] r_cnt;

  // Holds at zero instead of wrapping.
  always_ff @(posedge i_clk) begin
    if (!i_rstn)              r_cnt <= '0;
    else if (i_load)          r_cnt <= i_load_val;
    else if (r_cnt != '0)     r_cnt <= r_cnt - 1'b1;
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/sa_pg_seq.sv
// Power-gating sequencer: staggers bank sleep enables and isolation around a level request.
// Optional macro SA_PG_SEQ_FORCE_ON_EN adds pg_force_on, which holds the block in ON.
module sa_pg_seq
  import sa_pg_pkg::*;
#(
  parameter int NUM_BANKS = SA_PG_NUM_BANKS_DFLT,
  parameter int STEP_CYC  = SA_PG_STEP_CYC_DFLT,
  parameter int ISO_CYC   = SA_PG_ISO_CYC_DFLT
) (
  input  logic        autosa_core_clk,
  input  logic        autosa_core_rstn,
  sa_pg_seq_if.slave  bus
);
  localparam int CNT_W = sa_pg_cnt_w(STEP_CYC, ISO_CYC);
  localparam int IDX_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam logic [CNT_W-1:0] STEP_LD = CNT_W'(STEP_CYC - 1);
  localparam logic [CNT_W-1:0] ISO_LD  = CNT_W'(ISO_CYC - 1);

  sa_pg_state_e         r_state, w_state_nxt;
  logic [IDX_W-1:0]     r_idx, w_idx_nxt;
  logic                 w_cnt_load, w_cnt_zero, w_force;
  logic [CNT_W-1:0]     w_cnt_val;
  logic                 r_iso_en, r_busy, r_ack;
  logic [NUM_BANKS-1:0] r_bank;
  logic                 w_iso_nxt, w_busy_nxt, w_ack_nxt;
  logic [NUM_BANKS-1:0] w_bank_nxt;

`ifdef SA_PG_SEQ_FORCE_ON_EN
  assign w_force = bus.pg_force_on;
`else
  assign w_force = 1'b0;
`endif

  sa_pg_step_cnt #(.CNT_W(CNT_W)) u_step_cnt (
    .i_clk      (autosa_core_clk),
    .i_rstn     (autosa_core_rstn),
    .i_load     (w_cnt_load),
    .i_load_val (w_cnt_val),
    .o_zero     (w_cnt_zero)
  );

  // Outputs are registered from the current state, so they trail the state by one edge.
  always_ff @(posedge autosa_core_clk) begin
    if (!autosa_core_rstn) begin
      r_state  <= ST_ON;
      r_idx    <= '0;
      r_iso_en <= 1'b0;
      r_busy   <= 1'b0;
      r_ack    <= 1'b0;
      r_bank   <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_idx    <= w_idx_nxt;
      r_iso_en <= w_iso_nxt;
      r_busy   <= w_busy_nxt;
      r_ack    <= w_ack_nxt;
      r_bank   <= w_bank_nxt;
    end
  end

  // The last bank edge enters the settle state directly; its dwell is the settle time.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_cnt_load  = 1'b0;
    w_cnt_val   = STEP_LD;
    case (r_state)
      ST_ON: if (bus.pg_req && !w_force) begin
        w_state_nxt = ST_ISO_ON;
        w_cnt_load  = 1'b1;
        w_cnt_val   = ISO_LD;
      end
      ST_ISO_ON: if (w_cnt_zero) begin
        w_cnt_load  = 1'b1;
        w_idx_nxt   = '0;
        w_state_nxt = (NUM_BANKS == 1) ? ST_PD_SETTLE : ST_PD_STEP;
      end
      ST_PD_STEP: if (w_cnt_zero) begin
        w_cnt_load = 1'b1;
        if (int'(r_idx) == NUM_BANKS - 2) w_state_nxt = ST_PD_SETTLE;
        else                              w_idx_nxt   = r_idx + 1'b1;
      end
      ST_PD_SETTLE: if (w_cnt_zero) w_state_nxt = ST_OFF;
      ST_OFF: if (!bus.pg_req) begin
        w_cnt_load  = 1'b1;
        w_idx_nxt   = IDX_W'(NUM_BANKS - 1);
        w_state_nxt = (NUM_BANKS == 1) ? ST_PU_SETTLE : ST_PU_STEP;
      end
      ST_PU_STEP: if (w_cnt_zero) begin
        w_cnt_load = 1'b1;
        if (int'(r_idx) == 1) w_state_nxt = ST_PU_SETTLE;
        else                  w_idx_nxt   = r_idx - 1'b1;
      end
      ST_PU_SETTLE: if (w_cnt_zero) begin
        w_cnt_load  = 1'b1;
        w_cnt_val   = ISO_LD;
        w_state_nxt = ST_ISO_OFF;
      end
      ST_ISO_OFF: if (w_cnt_zero) w_state_nxt = ST_ON;
      default: w_state_nxt = ST_ON;
    endcase
  end

  always_comb begin
    w_iso_nxt  = 1'b1;
    w_busy_nxt = 1'b1;
    w_ack_nxt  = r_ack;
    w_bank_nxt = '0;
    case (r_state)
      ST_ON: begin
        w_iso_nxt  = 1'b0;
        w_busy_nxt = 1'b0;
        w_ack_nxt  = 1'b0;
      end
      ST_ISO_OFF: w_iso_nxt = 1'b0;
      ST_OFF: begin
        w_busy_nxt = 1'b0;
        w_ack_nxt  = 1'b1;
        w_bank_nxt = '1;
      end
      ST_PD_SETTLE: w_bank_nxt = '1;
      ST_PD_STEP: for (int k = 0; k < NUM_BANKS; k++) w_bank_nxt[k] = (k <= int'(r_idx));
      ST_PU_STEP: for (int k = 0; k < NUM_BANKS; k++) w_bank_nxt[k] = (k < int'(r_idx));
      default: ;
    endcase
  end

  assign bus.pg_ack     = r_ack;
  assign bus.pg_busy    = r_busy;
  assign bus.iso_en     = r_iso_en;
  assign bus.bank_pd_en = r_bank;

endmodule

// File: doc/sa_pg_seq.md
# sa_pg_seq

Power-gating sequencer for the always-on (PGAOPV) domain. It converts a single level-sensitive power-down request into staggered per-bank sleep enables and an isolation enable. This limits in-rush current on wake and keeps outputs clamped while banks are unpowered. Its outputs drive the always-on inverter/buffer chains that fan out to RAM-bank power switches, so it sits directly upstream of the always-on inverter cells. It answers the requester with a four-phase level handshake.

## Interface
Parameters:
- NUM_BANKS, 4: number of independently switched banks (≥1).
- STEP_CYC, 8: cycles between consecutive bank transitions, and the settle time after the last bank (≥1).
- ISO_CYC, 2: cycles between an isolation edge and the adjacent bank or ack edge (≥1).

Ports:
- autosa_core_clk  in  1  single clock; all state updates on the rising edge.
- autosa_core_rstn  in  1  reset, synchronous and active-low.
- pg_req  in  1  level request: 1 = power down, 0 = power up.
- pg_ack  out  1  reflects the completed power state: 1 = fully down, 0 = fully up.
- pg_busy  out  1  high while a sequence is in progress.
- iso_en  out  1  isolation clamp enable, active high.
- bank_pd_en  out  NUM_BANKS  per-bank sleep enable, active high; bit k drives bank k.

## Operation
- States: ON, ISO_ON, PD_STEP, PD_SETTLE, OFF, PU_STEP, PU_SETTLE, ISO_OFF.
- In ON, pg_req=1 → ISO_ON: assert iso_en, wait ISO_CYC.
- PD_STEP: assert bank_pd_en[0], then bank_pd_en[1], and so on, one bank every STEP_CYC, lowest index first.
- PD_SETTLE: wait STEP_CYC after the last bank, then go to OFF and set pg_ack=1.
- In OFF, pg_req=0 → PU_STEP: clear banks highest index first, one every STEP_CYC.
- PU_SETTLE: wait STEP_CYC after bank 0, then go to ISO_OFF.
- ISO_OFF: deassert iso_en, wait ISO_CYC, then go to ON and set pg_ack=0.
- pg_req is sampled only in ON and OFF. Changes during a sequence are ignored until the sequence completes.
  - If req disagrees with pg_ack at completion, the opposite sequence starts on the next cycle.
- bank_pd_en bits only ever change one at a time. The settled pattern is all zeros (ON) or all ones (OFF).
- iso_en is high whenever any bank_pd_en bit is high.
- Step counter: one down-counter of width $clog2(max(STEP_CYC,ISO_CYC)+1). It is loaded on every phase entry and never wraps.
- NUM_BANKS=1 degenerates cleanly: no inter-bank wait, settle only.

## Timing
- Reset values: pg_ack=0, pg_busy=0, iso_en=0, bank_pd_en=0, state=ON.
- Reset asserted mid-sequence forces all of the above on the next edge, with no staged wake. Integration must guarantee that rails tolerate this.
- Power-down, with pg_req=1 sampled at edge 0 in ON:
  - iso_en=1 and pg_busy=1 from cycle 1.
  - bank_pd_en[k]=1 from cycle 1+ISO_CYC+k·STEP_CYC.
  - pg_ack=1 and pg_busy=0 from cycle 1+ISO_CYC+NUM_BANKS·STEP_CYC.
- Power-up, with pg_req=0 sampled at edge 0 in OFF:
  - bank_pd_en[k]=0 from cycle 1+(NUM_BANKS-1-k)·STEP_CYC.
  - iso_en=0 from cycle 1+NUM_BANKS·STEP_CYC.
  - pg_ack=0 and pg_busy=0 from cycle 1+NUM_BANKS·STEP_CYC+ISO_CYC.
- Defaults give 35 cycles in each direction.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- SA_PG_SEQ_FORCE_ON_EN defined: adds input pg_force_on (1 bit).
  - While pg_force_on=1 in ON, pg_req is ignored, so the block stays ON with pg_ack=0.
  - pg_force_on does not abort a sequence already in progress. If it is high when a power-up completes, the block remains ON.
- Macro undefined: the port is absent and behaviour is as above.

## Structure
- Package sa_pg_pkg holds:
  - the state enum;
  - default parameter constants (SA_PG_NUM_BANKS_DFLT=4, SA_PG_STEP_CYC_DFLT=8, SA_PG_ISO_CYC_DFLT=2);
  - a counter-width function.
- Sub-module sa_pg_step_cnt: loadable down-counter with a zero flag, shared by all wait phases.
- The bank index register and output registers live in sa_pg_seq.

## Test plan
- Reset with defaults, pulse rstn=0 for 2 cycles → all outputs 0 and state ON.
- Power-down: pg_req=1 at edge 0 → iso_en at 1, bank_pd_en=0001/0011/0111/1111 at 3/11/19/27, pg_ack=1 at 35, pg_busy high over cycles 1..34.
- Power-up from OFF: pg_req=0 → bank_pd_en=0111/0011/0001/0000 at 1/9/17/25, iso_en=0 at 33, pg_ack=0 at 35.
- Req toggled mid-sequence: pg_req 1→0 at cycle 10 of power-down → power-down completes (ack=1 at 35), power-up starts at 36, ack=0 at 70.
- Reset at cycle 15 of power-down → next edge all outputs 0, and a following pg_req=1 runs a full 35-cycle sequence.
- With SA_PG_SEQ_FORCE_ON_EN, pg_force_on=1 and pg_req=1 held 50 cycles → iso_en, bank_pd_en and pg_ack stay 0; dropping force_on starts power-down on the next cycle.
